uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg_if.sv | 24 ++
 rtl/uart_rx_cfg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg_if.sv
// FIFO read-side bundle of the configurable UART receiver.
// The receiver is the slave; the consumer drives rd_en as master.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 rd_en;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 fifo_full;

    modport master (
        output rd_en,
        input  data_out,
        input  data_valid,
        input  fifo_full
    );

    modport slave (
        input  rd_en,
        output data_out,
        output data_valid,
        output fifo_full
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with mid-bit sampling, parity/stop checks,
// sticky overrun and a first-word-fall-through receive FIFO.
module uart_rx_cfg #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 57600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          data_rx,
    input  logic          err_clr,
    uart_rx_cfg_if.slave  fifo,
    output logic          over_rx,
    output logic          frame_err,
    output logic          parity_err,
    output logic          overrun
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, WAIT_HI
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 prev_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [AW:0]          count_q, count_d;
    logic                 over_rx_q, frame_err_q, parity_err_q;
    logic                 overrun_q, overrun_d;

    logic rx_s, tick, good, ferr, perr_pulse;
    logic full, empty, push, pop, ovr_set;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        good       = 1'b0;
        ferr       = 1'b0;
        perr_pulse = 1'b0;
        if (state_q != IDLE && state_q != WAIT_HI) begin
            cnt_d = tick ? CW'(DIV - 1) : cnt_q - CW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = CW'(DIV / 2 - 1);
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    perr_d  = (^{shift_q, rx_s}) != ODD;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!rx_s) begin
                        ferr    = 1'b1;
                        state_d = WAIT_HI;
                    end else if (bit_q == 3'(STOP_BITS - 1)) begin
                        state_d    = IDLE;
                        perr_pulse = perr_q;
                        good       = !perr_q;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            WAIT_HI: begin
                if (rx_s) state_d = IDLE;
            end
        endcase
    end

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign pop     = fifo.rd_en && !empty;
    // A pop frees the slot the same cycle, so a full FIFO still accepts
    assign push    = good && (!full || pop);
    assign ovr_set = good && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + (AW+1)'(1);
        if (pop && !push) count_d = count_q - (AW+1)'(1);
        overrun_d = overrun_q;
        if (err_clr) overrun_d = 1'b0;
        if (ovr_set) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            over_rx_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], data_rx};
            prev_q       <= rx_s;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            count_q      <= count_d;
            over_rx_q    <= push;
            frame_err_q  <= ferr;
            parity_err_q <= perr_pulse;
            overrun_q    <= overrun_d;
            if (push) begin
                mem_q[wr_q] <= shift_q;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
        end
    end

    assign fifo.data_out   = mem_q[rd_q];
    assign fifo.data_valid = !empty;
    assign fifo.fifo_full  = full;
    assign over_rx         = over_rx_q;
    assign frame_err       = frame_err_q;
    assign parity_err      = parity_err_q;
    assign overrun         = overrun_q;
endmodule
